// File: rtl/systolic_result_streamer.sv
// Captures the multiplier's packed result bus on a done edge and streams it
// one element per beat over valid/ready, tagged with row/col and a last flag.
module systolic_result_streamer #(
  parameter int RESULT_WIDTH = 16,
  parameter int M            = 8,
  parameter int P            = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           done_in,
  input  logic [M*P*RESULT_WIDTH-1:0]    result_c,
  input  logic                           col_major,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [RESULT_WIDTH-1:0]        m_data,
  output logic [((M>1)?$clog2(M):1)-1:0] m_row,
  output logic [((P>1)?$clog2(P):1)-1:0] m_col,
  output logic                           m_last,
  output logic                           busy,
  output logic                           overrun
);

  localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
  localparam int COL_W = (P > 1) ? $clog2(P) : 1;
  localparam int NELEM = M * P;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                      state_q, state_d;
  logic                        done_q;
  logic [NELEM*RESULT_WIDTH-1:0] snap_q, snap_d;
  logic                        colmaj_q, colmaj_d;
  logic                        valid_q, valid_d;
  logic [RESULT_WIDTH-1:0]     data_q, data_d;
  logic [ROW_W-1:0]            row_q, row_d, nrow;
  logic [COL_W-1:0]            col_q, col_d, ncol;
  logic                        last_q, last_d;
  logic                        ovr_q, ovr_d;
  logic                        done_edge, hs, final_hs;

  function automatic logic [RESULT_WIDTH-1:0] pick_elem(
    input logic [NELEM*RESULT_WIDTH-1:0] bus,
    input logic [ROW_W-1:0]              r,
    input logic [COL_W-1:0]              c
  );
    logic [RESULT_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NELEM; k++) begin
      if (k == int'(r) * P + int'(c)) v = bus[k*RESULT_WIDTH +: RESULT_WIDTH];
    end
    return v;
  endfunction

  assign done_edge = done_in & ~done_q;
  assign hs        = valid_q & m_ready;
  assign final_hs  = hs & last_q;

  // Next element position in the order latched at capture.
  always_comb begin
    nrow = row_q;
    ncol = col_q;
    if (!colmaj_q) begin
      if (col_q == COL_W'(P - 1)) begin
        ncol = '0;
        nrow = row_q + 1'b1;
      end else begin
        ncol = col_q + 1'b1;
      end
    end else begin
      if (row_q == ROW_W'(M - 1)) begin
        nrow = '0;
        ncol = col_q + 1'b1;
      end else begin
        nrow = row_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    colmaj_d = colmaj_q;
    valid_d  = valid_q;
    data_d   = data_q;
    row_d    = row_q;
    col_d    = col_q;
    last_d   = last_q;
    ovr_d    = ovr_q;
    case (state_q)
      STREAM: begin
        if (final_hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (hs) begin
          row_d  = nrow;
          col_d  = ncol;
          data_d = pick_elem(snap_q, nrow, ncol);
          last_d = (nrow == ROW_W'(M - 1)) && (ncol == COL_W'(P - 1));
        end
        if (done_edge && !final_hs) ovr_d = 1'b1;
      end
      default: ;
    endcase
    // A done edge on the final handshake chains straight into the next frame.
    if (done_edge && ((state_q == IDLE) || final_hs)) begin
      snap_d   = result_c;
      colmaj_d = col_major;
      valid_d  = 1'b1;
      row_d    = '0;
      col_d    = '0;
      data_d   = result_c[RESULT_WIDTH-1:0];
      last_d   = (NELEM == 1);
      state_d  = STREAM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      snap_q   <= '0;
      colmaj_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_in;
      snap_q   <= snap_d;
      colmaj_q <= colmaj_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      row_q    <= row_d;
      col_q    <= col_d;
      last_q   <= last_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_row   = row_q;
  assign m_col   = col_q;
  assign m_last  = last_q;
  assign busy    = (state_q == STREAM);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_systolic_result_streamer.sv
// Randomized bench for systolic_result_streamer against a frame-queue model
// of the expected beat stream.
module tb_systolic_result_streamer;

  localparam int RW = 16;
  localparam int M  = 8;
  localparam int P  = 8;

  logic                clk;
  logic                rst_n;
  logic                done_in;
  logic [M*P*RW-1:0]   rc;
  logic                col_major;
  logic                m_valid;
  logic                m_ready;
  logic [RW-1:0]       m_data;
  logic [2:0]          m_row;
  logic [2:0]          m_col;
  logic                m_last;
  logic                busy;
  logic                overrun;

  systolic_result_streamer #(.RESULT_WIDTH(RW), .M(M), .P(P)) dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in), .result_c(rc),
    .col_major(col_major), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] d;
    int            r;
    int            c;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  bit    mdl_ovr;
  bit    mdl_done;
  int    n_tests;
  int    n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The expected frame is just the element list in the chosen visiting order.
  function automatic void push_frame(input logic [M*P*RW-1:0] bus, input bit cm);
    beat_t b;
    int    n;
    n = 0;
    for (int a = 0; a < (cm ? P : M); a++) begin
      for (int e = 0; e < (cm ? M : P); e++) begin
        b.r    = cm ? e : a;
        b.c    = cm ? a : e;
        b.d    = bus[(b.r*P + b.c)*RW +: RW];
        n++;
        b.last = (n == M*P);
        exp_q.push_back(b);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_valid", 32'(m_valid), 32'd0);
      check_eq("rst_data", 32'(m_data), 32'd0);
      check_eq("rst_row", 32'(m_row), 32'd0);
      check_eq("rst_col", 32'(m_col), 32'd0);
      check_eq("rst_last", 32'(m_last), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_overrun", 32'(overrun), 32'd0);
      exp_q.delete();
      mdl_ovr  = 1'b0;
      mdl_done = 1'b0;
    end else begin
      check_eq("valid", 32'(m_valid), 32'(exp_q.size() != 0));
      check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
      check_eq("overrun", 32'(overrun), 32'(mdl_ovr));
      if (exp_q.size() != 0) begin
        check_eq("data", 32'(m_data), 32'(exp_q[0].d));
        check_eq("row", 32'(m_row), 32'(exp_q[0].r));
        check_eq("col", 32'(m_col), 32'(exp_q[0].c));
        check_eq("last", 32'(m_last), 32'(exp_q[0].last));
        if (m_ready) void'(exp_q.pop_front());
      end
      if (done_in && !mdl_done) begin
        if (exp_q.size() == 0) push_frame(rc, col_major);
        else mdl_ovr = 1'b1;
      end
      mdl_done = done_in;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    step();
  endtask

  task automatic wait_size(input int target);
    int t;
    t = 0;
    while (exp_q.size() != target && t < 2000) begin
      step();
      t++;
    end
    if (t >= 2000) check_eq("timeout", 32'd1, 32'd0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < M*P; k++) rc[k*RW +: RW] = RW'($urandom);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    done_in   = 1'b1;
    m_ready   = 1'b1;
    col_major = 1'b0;
    fill_random();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    done_in = 1'b0;
    wait_size(0);
    step();

    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) rc[(i*P + j)*RW +: RW] = RW'(16*i + j);
    pulse_done();
    wait_size(0);
    step();
    col_major = 1'b1;
    pulse_done();
    wait_size(0);
    step();

    fill_random();
    rc[(3*P + 5)*RW +: RW] = 16'hFF85;
    col_major = 1'b0;
    pulse_done();
    for (int cnt = 0; cnt < 1000 && exp_q.size() != 0; cnt++) begin
      m_ready = (cnt % 4 == 0) || (cnt % 4 == 3);
      rc[RW-1:0] = RW'($urandom);
      step();
    end
    m_ready = 1'b1;
    wait_size(0);
    step();

    fill_random();
    pulse_done();
    wait_size(M*P - 20);
    pulse_done();
    fill_random();
    wait_size(0);
    step();
    pulse_done();
    fill_random();
    wait_size(1);
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    wait_size(0);
    step();

    pulse_done();
    wait_size(M*P - 30);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    fill_random();
    pulse_done();
    wait_size(0);

    for (int cyc = 0; cyc < 600; cyc++) begin
      m_ready   = ($urandom % 4) != 0;
      done_in   = ($urandom % 12) == 0;
      col_major = $urandom % 2;
      if ($urandom % 8 == 0) rc[($urandom % (M*P))*RW +: RW] = RW'($urandom);
      step();
    end
    done_in = 1'b0;
    m_ready = 1'b1;
    wait_size(0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_streamer.md
Name: systolic_result_streamer

Overview:
- Consumer end of the systolic_matrix_multiplier result interface.
- On the multiplier's done, snapshots the packed result_c bus (M*P elements of RESULT_WIDTH).
- Streams the snapshot out one element per beat over a valid/ready interface, tagged with row/col indices and a last flag.
- Frees the multiplier to start its next job immediately after capture.

Parameters:
- RESULT_WIDTH, 16, bits per result element (matches the multiplier's RESULT_WIDTH).
- M, 8, result rows.
- P, 8, result columns.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- done_in  input  1  multiplier done (level or pulse; only the rising edge matters).
- result_c  input  M*P*RESULT_WIDTH  packed results; element (i,j) at bits [(i*P+j)*RESULT_WIDTH +: RESULT_WIDTH].
- col_major  input  1  stream order select, sampled at capture (0 = row-major, 1 = column-major).
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  RESULT_WIDTH  element value, bit-exact copy of the captured field.
- m_row  output  clog2(M) (min 1)  row index i of the current beat.
- m_col  output  clog2(P) (min 1)  column index j of the current beat.
- m_last  output  1  high on the final beat (M*P-th) of a frame.
- busy  output  1  a captured frame is not yet fully streamed.
- overrun  output  1  sticky; a done edge arrived while busy and was dropped.

Behaviour:
- Reset (rst_n low, async): state IDLE; m_valid=0, m_data=0, m_row=0, m_col=0, m_last=0, busy=0, overrun=0, done-edge history=0, snapshot cleared.
- Edge detect: done_edge = done_in & ~done_q, where done_q is done_in registered each clock.
- State IDLE: on done_edge at edge k, capture result_c into the shadow register and latch col_major. At the same edge set m_valid=1, busy=1, indices (0,0), m_data=C[0][0]; go to STREAM.
- Latency: first beat is visible in the cycle after done_in is first sampled high.
- State STREAM:
  - A handshake is m_valid & m_ready at a rising edge.
  - m_data/m_row/m_col/m_last must hold stable while m_valid & ~m_ready.
  - On each handshake, advance to the next element.
  - Row-major: j increments; at j=P-1, j wraps to 0 and i increments.
  - Column-major: i increments; at i=M-1, i wraps to 0 and j increments.
  - m_last=1 exactly when the beat is (M-1,P-1); this is the final beat in both orders.
  - Full-rate: 1 beat/cycle with m_ready held high; a frame takes M*P cycles.
- Handshake on the m_last beat: m_valid=0, busy=0, m_last=0; return to IDLE. m_data may hold its last value.
- done_edge during STREAM, except on the final handshake cycle: ignored; snapshot unchanged; overrun<=1.
- done_edge in the same cycle as the final-beat handshake: accepted as a new capture, back-to-back. Next cycle m_valid=1 with the new C[0][0], busy stays 1, no overrun, zero-gap frames.
- done_in held high: only one capture, no overrun from the level. A new capture requires done_in to go low then high.
- result_c changes after capture: no effect on the frame in flight.
- overrun: cleared only by rst_n.
- Reset mid-frame: all outputs return to reset values asynchronously; the partial frame is discarded. After release, IDLE waits for a fresh done edge. A done_in already high at release counts as an edge at the first clock, since done_q resets to 0.
- M=1 or P=1: indices degenerate correctly; m_last is on beat M*P-1.
- No arithmetic is performed; data is a pure bit copy (signed values preserved).

Test Plan:
- Reset values: rst_n low for 3 cycles with done_in=1 -> all outputs 0. After release, done_in still high -> capture on the first edge, m_valid=1 next cycle.
- Row-major, M=P=8, C[i][j]=16*i+j, m_ready=1, col_major=0 -> 64 consecutive beats.
  - Beat 0: data 0x0000, (0,0).
  - Beat 9: 0x0011, (1,1).
  - Beat 63: 0x0077, m_last=1.
  - Then m_valid=0, busy=0.
- Column-major, same data, col_major=1 -> beat 1 = 0x0010 (1,0); beat 8 = 0x0001 (0,1); beat 63 = 0x0077 with m_last.
- Backpressure: m_ready toggles 1,0,0,1 repeating -> outputs stable through ready-low cycles; each element delivered exactly once in order; signed value 0xFF85 (-123) passes unchanged.
- Overrun and back-to-back:
  - Second done pulse at beat 20 -> overrun=1, frame unaltered, busy drops after beat 63.
  - done pulse coincident with the beat-63 handshake -> next cycle new frame beat 0, overrun unchanged.
- Reset mid-stream: assert rst_n low at beat 30 -> immediate m_valid=0, busy=0, overrun=0. New done -> full 64-beat frame starting at (0,0).
